// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of the 64 x 8 data memory.
// Optional build macro: DMEM_ARB_RANGE_CHECK_EN (reject addresses >= DEPTH with err).
module dmem_arbiter #(
    parameter int DEPTH = 64,
    parameter int AW    = 8,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          done0,
    output logic          done1,
    output logic [DW-1:0] rdata,
    output logic          err,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] write_data_M,
    output logic          write_en,
    output logic          read_en,
    output logic [2:0]    opcode,
    input  logic [DW-1:0] read_data
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;

    state_t        state, state_nxt;
    logic          owner, last_served, pick;
    logic          lat_we;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic          range_err;

`ifdef DMEM_ARB_RANGE_CHECK_EN
    assign range_err = ({1'b0, lat_addr} >= (AW+1)'(DEPTH));
`else
    // Bound is masked off so both builds reference DEPTH identically.
    assign range_err = 1'b0 & ({1'b0, lat_addr} >= (AW+1)'(DEPTH));
`endif

    // Round-robin: on contention, serve whoever was not served last.
    always_comb begin
        if (req0 && req1) pick = ~last_served;
        else              pick = req1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_nxt    = state;
        mem_addr     = '0;
        write_data_M = '0;
        write_en     = 1'b0;
        read_en      = 1'b0;
        opcode       = OP_LOAD;
        gnt0         = (state != IDLE) && !owner;
        gnt1         = (state != IDLE) &&  owner;
        done0        = 1'b0;
        done1        = 1'b0;
        err          = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) state_nxt = ACCESS;
            end
            ACCESS: begin
                mem_addr     = lat_addr;
                write_data_M = lat_wdata;
                if (!range_err) begin
                    if (lat_we) begin
                        write_en = 1'b1;
                        opcode   = OP_STORE;
                    end else begin
                        read_en  = 1'b1;
                    end
                end
                state_nxt = RESP;
            end
            RESP: begin
                done0     = !owner;
                done1     =  owner;
                err       = range_err;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner       <= 1'b0;
            last_served <= 1'b1;
            lat_we      <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            rdata       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        owner     <= pick;
                        lat_we    <= pick ? we1    : we0;
                        lat_addr  <= pick ? addr1  : addr0;
                        lat_wdata <= pick ? wdata1 : wdata0;
                    end
                end
                ACCESS: begin
                    last_served <= owner;
                    rdata       <= (!lat_we && !range_err) ? read_data : '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural 64 x 8 memory.
// Build with DMEM_ARB_RANGE_CHECK_EN to exercise the range-error path.
module tb_dmem_arbiter;

    logic       clk, reset;
    logic       req0, we0, req1, we1;
    logic [7:0] addr0, wdata0, addr1, wdata1;
    logic       gnt0, gnt1, done0, done1, err, write_en, read_en;
    logic [7:0] rdata, mem_addr, write_data_M, read_data;
    logic [2:0] opcode;

    int n_cmp  = 0;
    int n_fail = 0;

    dmem_arbiter dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata(rdata), .err(err), .mem_addr(mem_addr),
        .write_data_M(write_data_M), .write_en(write_en), .read_en(read_en),
        .opcode(opcode), .read_data(read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: reset image has 8'hED at word 1, zero elsewhere.
    logic [7:0] mem [64];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 64; i++) mem[i] <= (i == 1) ? 8'hED : 8'h00;
        end else if (write_en) begin
            mem[mem_addr[5:0]] <= write_data_M;
        end
    end
    assign read_data = mem[mem_addr[5:0]];

    // {gnt0,gnt1,done0,done1,err,write_en,read_en,opcode}
    localparam logic [9:0] C_IDLE    = 10'b00_00_0_00_000;
    localparam logic [9:0] C_LD0     = 10'b10_00_0_01_000;
    localparam logic [9:0] C_LD1     = 10'b01_00_0_01_000;
    localparam logic [9:0] C_ST0     = 10'b10_00_0_10_001;
    localparam logic [9:0] C_ST1     = 10'b01_00_0_10_001;
    localparam logic [9:0] C_RSP0    = 10'b10_10_0_00_000;
    localparam logic [9:0] C_RSP1    = 10'b01_01_0_00_000;
    localparam logic [9:0] C_ACC0_NO = 10'b10_00_0_00_000;
    localparam logic [9:0] C_RSP0_ER = 10'b10_10_1_00_000;

    function automatic logic [9:0] ctl();
        return {gnt0, gnt1, done0, done1, err, write_en, read_en, opcode};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Store and load enables must never overlap.
    always @(negedge clk) begin
        if (reset) check("excl_en", {31'd0, write_en & read_en}, 32'd0);
    end

    logic [9:0] exp_acc [4] = '{C_LD0, C_LD1, C_LD0, C_LD1};
    logic [9:0] exp_rsp [4] = '{C_RSP0, C_RSP1, C_RSP0, C_RSP1};
    logic [7:0] exp_dat [4] = '{8'hED, 8'h00, 8'hED, 8'h00};

    initial begin
        reset = 1'b0;
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
        #2;
        check("rst_ctl", 32'(ctl()), 32'(C_IDLE));
        check("rst_bus", {8'd0, mem_addr, write_data_M, rdata}, 32'd0);
        tick(); tick();
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_ctl", 32'(ctl()), 32'(C_IDLE));
        end

        // Continuous contention: pointer resets to 1, so order is 0,1,0,1.
        req0 = 1; we0 = 0; addr0 = 8'd1;
        req1 = 1; we1 = 0; addr1 = 8'd0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rr_acc", 32'(ctl()), 32'(exp_acc[i]));
            tick();
            check("rr_rsp", 32'(ctl()), 32'(exp_rsp[i]));
            check("rr_rdata", 32'(rdata), 32'(exp_dat[i]));
            if (i == 3) begin req0 = 0; req1 = 0; end
            tick();
            check("rr_gap", 32'(ctl()), 32'(C_IDLE));
        end

        // Single load from word 1.
        req0 = 1; we0 = 0; addr0 = 8'd1;
        tick();
        check("ld1_acc", 32'(ctl()), 32'(C_LD0));
        check("ld1_addr", 32'(mem_addr), 32'd1);
        tick();
        check("ld1_rsp", 32'(ctl()), 32'(C_RSP0));
        check("ld1_rdata", 32'(rdata), 32'hED);
        req0 = 0;
        tick();
        check("ld1_end", 32'(ctl()), 32'(C_IDLE));

        // Store from port 1, then load back from port 0.
        req1 = 1; we1 = 1; addr1 = 8'd5; wdata1 = 8'h3C;
        tick();
        check("st5_acc", 32'(ctl()), 32'(C_ST1));
        check("st5_bus", {16'd0, mem_addr, write_data_M}, {16'd0, 8'd5, 8'h3C});
        tick();
        check("st5_rsp", 32'(ctl()), 32'(C_RSP1));
        check("st5_rdata", 32'(rdata), 32'h00);
        req1 = 0; req0 = 1; we0 = 0; addr0 = 8'd5;
        tick();
        check("st5_end", 32'(ctl()), 32'(C_IDLE));
        tick();
        check("ld5_acc", 32'(ctl()), 32'(C_LD0));
        addr0 = 8'd9;
        #1;
        check("ld5_latched", 32'(mem_addr), 32'd5);
        tick();
        check("ld5_rsp", 32'(ctl()), 32'(C_RSP0));
        check("ld5_rdata", 32'(rdata), 32'h3C);
        req0 = 0;
        tick();

        // Reset during ACCESS of a store to word 7.
        req0 = 1; we0 = 1; addr0 = 8'd7; wdata0 = 8'hAA;
        tick();
        check("st7_acc", 32'(ctl()), 32'(C_ST0));
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_ctl", 32'(ctl()), 32'(C_IDLE));
        check("mid_rst_bus", {8'd0, mem_addr, write_data_M, rdata}, 32'd0);
        req0 = 0;
        tick();
        reset = 1'b1;
        tick();
        req0 = 1; we0 = 0; addr0 = 8'd7;
        tick();
        check("ld7_acc", 32'(ctl()), 32'(C_LD0));
        tick();
        check("ld7_rsp", 32'(ctl()), 32'(C_RSP0));
        check("ld7_rdata", 32'(rdata), 32'h00);
        req0 = 0;
        tick();

        // Out-of-range store to address 70.
        req0 = 1; we0 = 1; addr0 = 8'd70; wdata0 = 8'h55;
        tick();
`ifdef DMEM_ARB_RANGE_CHECK_EN
        check("oor_acc", 32'(ctl()), 32'(C_ACC0_NO));
        tick();
        check("oor_rsp", 32'(ctl()), 32'(C_RSP0_ER));
        check("oor_rdata", 32'(rdata), 32'h00);
`else
        check("oor_acc", 32'(ctl()), 32'(C_ST0));
        check("oor_addr", 32'(mem_addr), 32'd70);
        tick();
        check("oor_rsp", 32'(ctl()), 32'(C_RSP0));
`endif
        req0 = 0;
        tick();
        check("final_idle", 32'(ctl()), 32'(C_IDLE));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
